// File: rtl/regarb_pkg.sv
// Shared types and defaults for the register write arbiter.
package regarb_pkg;

    localparam int unsigned DATA_W_DEF = 16;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t WRITE = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority one-hot picker: searches ptr, ptr+1, ... mod NUM_REQ.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic             found;
    logic [PTR_W-1:0] pos;

    always_comb begin
        grant = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[pos]) begin
                grant[pos] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates NUM_REQ requesters onto one register-bank write port, one write per two cycles.
// Define REGARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module reg_write_arbiter
    import regarb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*IDX_W-1:0]  req_idx,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REGS-1:0]       w_flag,
    output logic [DATA_W-1:0]         wdata,
    output logic                      busy
);

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  win_q;
    logic [IDX_W-1:0]    idx_q, sel_idx;
    logic [DATA_W-1:0]   data_q, sel_data;
    logic [PTR_W-1:0]    ptr;
    logic                start;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req   (req),
        .ptr   (ptr),
        .grant (grant)
    );

    assign start = (state_q == IDLE) && (|req);

    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                sel_idx  = req_idx[i*IDX_W +: IDX_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef REGARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [PTR_W-1:0] ptr_q, ptr_next, win_num;

    always_comb begin
        win_num = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) win_num = PTR_W'(i);
        end
        ptr_next = (win_num == PTR_W'(NUM_REQ - 1)) ? '0 : win_num + PTR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (start) begin
            ptr_q <= ptr_next;
        end
    end

    assign ptr = ptr_q;
`endif

    always_comb begin
        state_d = IDLE;
        if (state_q == IDLE && start) state_d = WRITE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                win_q  <= grant;
                idx_q  <= sel_idx;
                data_q <= sel_data;
            end
        end
    end

    assign busy  = (state_q == WRITE);
    assign ack   = busy ? win_q : '0;
    assign wdata = busy ? data_q : '0;

    // Register 0 is hardwired zero and out-of-range indices match no bit.
    always_comb begin
        w_flag = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            w_flag[i] = busy && (idx_q == IDX_W'(i));
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: stimulus pushes expected writes, monitor pops on busy.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] req_idx;
    logic [63:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  w_flag;
    logic [15:0] wdata;
    logic        busy;

    typedef struct packed {
        logic [3:0]  ack;
        logic [7:0]  w_flag;
        logic [15:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    reg_write_arbiter u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_idx  (req_idx),
        .req_data (req_data),
        .ack      (ack),
        .w_flag   (w_flag),
        .wdata    (wdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] idx, input logic [15:0] data);
        req_idx[i*3 +: 3]   = idx;
        req_data[i*16 +: 16] = data;
    endtask

    task automatic push(input logic [3:0] a, input logic [7:0] f, input logic [15:0] d);
        exp_t x;
        x.ack    = a;
        x.w_flag = f;
        x.wdata  = d;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: actual=%h required=none", {ack, w_flag, wdata});
                end else begin
                    e = exp_q.pop_front();
                    check("write", {4'h0, ack, w_flag, wdata}, {4'h0, e});
                end
            end else begin
                check("idle_outputs", {3'h0, busy, ack, w_flag, wdata}, 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_idx  = '0;
        req_data = '0;
        #1;
        check("reset_outputs", {3'h0, busy, ack, w_flag, wdata}, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Single request to register 3.
        set_req(1, 3'd3, 16'h00A5);
        req = 4'b0010;
        push(4'b0010, 8'b0000_1000, 16'h00A5);
        tick();
        req = 4'b0000;
        tick();
        tick();

        // Zero register: ack pulses but no write enable.
        set_req(0, 3'd0, 16'hFFFF);
        req = 4'b0001;
        push(4'b0001, 8'b0000_0000, 16'hFFFF);
        tick();
        req = 4'b0000;
        tick();
        tick();

        // Data changes after capture must not reach wdata.
        set_req(0, 3'd5, 16'h1234);
        req = 4'b0001;
        push(4'b0001, 8'b0010_0000, 16'h1234);
        tick();
        set_req(0, 3'd5, 16'h5678);
        req = 4'b0000;
        tick();
        tick();

        // All requesters held from a fresh pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 3'(i + 1), 16'h1000 + 16'(i));
`ifdef REGARB_FIXED_PRIO_EN
        for (int n = 0; n < 5; n++) push(4'b0001, 8'b0000_0010, 16'h1000);
`else
        push(4'b0001, 8'b0000_0010, 16'h1000);
        push(4'b0010, 8'b0000_0100, 16'h1001);
        push(4'b0100, 8'b0000_1000, 16'h1002);
        push(4'b1000, 8'b0001_0000, 16'h1003);
        push(4'b0001, 8'b0000_0010, 16'h1000);
`endif
        req = 4'b1111;
        repeat (9) tick();
        req = 4'b0000;
        tick();
        tick();

        // Reset in the middle of a write drops it; held request wins after release.
        set_req(2, 3'd4, 16'hCAFE);
        req = 4'b0100;
        tick();
        check("busy_in_write", {31'h0, busy}, 32'h1);
        check("ack_in_write", {28'h0, ack}, 32'h4);
        #1;
        rst = 1'b1;
        #1;
        check("abort_outputs", {3'h0, busy, ack, w_flag, wdata}, 32'h0);
        push(4'b0100, 8'b0001_0000, 16'hCAFE);
        tick();
        rst = 1'b0;
        tick();
        req = 4'b0000;
        tick();
        tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
